mult_share_arbiter: RTL and testbench

Round-robin arbiter and 2-stage pipeline that shares one `Wallace_8bit` multiplier among `N_REQ` requesters, such as systolic-array PE columns or preprocessing engines.

- Each requester presents an 8-bit operand pair through a valid/ready handshake.
- The block grants one requester per cycle, registers its operands, multiplies them, and returns a tagged 16-bit product on one shared response port with backpressure.
- A saturating operation counter is exposed for status.

---
 rtl/mult_arb_pkg.sv | 39 +++
 rtl/Wallace_8bit.sv | 39 +++
 rtl/mult_share_arbiter.sv | 103 ++++++++++
 tb/tb_mult_share_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// Holds operand widths, the S1 bundle and the round-robin picker.
package mult_arb_pkg;

  localparam int OPND_W   = 8;
  localparam int PROD_W   = 16;
  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    logic [OPND_W-1:0]   a;
    logic [OPND_W-1:0]   b;
  } s1_t;

  // First set bit of vld at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  vld,
    input logic [MAX_ID_W-1:0] ptr,
    input logic [4:0]          n
  );
    logic [MAX_REQ-1:0] gnt;
    logic [4:0]         idx;
    logic               hit;
    gnt = '0;
    hit = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= n) idx = idx - n;
      if (!hit && (5'(k) < n) && vld[idx[3:0]]) begin
        gnt[idx[3:0]] = 1'b1;
        hit = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/Wallace_8bit.sv
// 8x8 unsigned Wallace-tree multiplier, word-level 3:2 reduction.
// Nonzero APPROX drops the low nibble of every partial product.
module Wallace_8bit #(
  parameter int APPROX = 0
) (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] pp [8];
  logic [15:0] s  [6];
  logic [15:0] c  [6];

  function automatic logic [31:0] csa(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    logic [15:0] cy;
    cy = ((x & y) | (x & z) | (y & z)) << 1;
    return {cy, x ^ y ^ z};
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = 16'(a & {8{b[i]}}) << i;
      if (APPROX != 0) pp[i] = pp[i] & 16'hFFF0;
    end
    {c[0], s[0]} = csa(pp[0], pp[1], pp[2]);
    {c[1], s[1]} = csa(pp[3], pp[4], pp[5]);
    {c[2], s[2]} = csa(s[0], c[0], s[1]);
    {c[3], s[3]} = csa(c[1], pp[6], pp[7]);
    {c[4], s[4]} = csa(s[2], c[2], s[3]);
    {c[5], s[5]} = csa(s[4], c[4], c[3]);
    p = s[5] + c[5];
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one Wallace multiplier among N_REQ
// requesters through an operand stage and a result stage.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ID_W   = $clog2(N_REQ),
  parameter int APPROX = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*8-1:0]  req_a,
  input  logic [N_REQ*8-1:0]  req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [PROD_W-1:0]   rsp_data,
  input  logic                rsp_ready,
  output logic [15:0]         op_count
);

  s1_t                s1;
  logic [ID_W-1:0]    rr_ptr;
  logic               s2_free;
  logic               s1_free;
  logic [MAX_REQ-1:0] pick;
  logic [N_REQ-1:0]   hs_vec;
  logic               hs;
  logic [ID_W-1:0]    gid;
  logic [ID_W-1:0]    nxt_ptr;
  logic [OPND_W-1:0]  a_sel;
  logic [OPND_W-1:0]  b_sel;
  logic [PROD_W-1:0]  prod;
  logic               unused_bits;

  assign s2_free = !rsp_valid || rsp_ready;
  assign s1_free = !s1.valid || s2_free;

  assign pick = rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(rr_ptr),
                        5'(N_REQ));

  // Gated by rst_n so nothing is granted while reset is held.
  assign req_ready = (rst_n && s1_free) ? pick[N_REQ-1:0] : '0;
  assign hs_vec    = req_valid & req_ready;
  assign hs        = |hs_vec;

  assign unused_bits = ^{pick, s1.id};

  always_comb begin
    gid   = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (hs_vec[i]) begin
        gid   = ID_W'(i);
        a_sel = req_a[8*i +: 8];
        b_sel = req_b[8*i +: 8];
      end
    end
  end

  assign nxt_ptr = (gid == ID_W'(N_REQ-1)) ? '0 : gid + 1'b1;

  Wallace_8bit #(
    .APPROX(APPROX)
  ) u_mul (
    .a(s1.a),
    .b(s1.b),
    .p(prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      op_count  <= '0;
    end else begin
      if (s2_free) begin
        rsp_valid <= s1.valid;
        if (s1.valid) begin
          rsp_id   <= s1.id[ID_W-1:0];
          rsp_data <= prod;
        end
      end
      if (s1_free) begin
        s1.valid <= hs;
        if (hs) begin
          s1.id <= MAX_ID_W'(gid);
          s1.a  <= a_sel;
          s1.b  <= b_sel;
        end
      end
      if (hs) rr_ptr <= nxt_ptr;
      if (rsp_valid && rsp_ready && (op_count != 16'hFFFF))
        op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter, N_REQ=4.
// Inputs change at posedge+1; outputs are sampled inside the window.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_data;
  logic          rsp_ready;
  logic [15:0]   op_count;

  int total = 0;
  int bad   = 0;

  mult_share_arbiter #(
    .N_REQ(N),
    .APPROX(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_ready(rsp_ready),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a,
                        input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  function automatic logic [7:0] op_a(input int c);
    if (c == 0) return 8'd255;
    if (c == 1) return 8'd0;
    return 8'((c - 2) / 32);
  endfunction

  function automatic logic [7:0] op_b(input int c);
    if (c == 0) return 8'd255;
    if (c == 1) return 8'd200;
    return 8'((c - 2) % 32);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int nx;
    logic [15:0] e16;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_cnt", op_count, 0);
    tick();
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    tick();

    // single request from requester 2
    set_op(2, 8'd13, 8'd11);
    req_valid = 4'b0100;
    #1;
    chk("single_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("single_lat", rsp_valid, 0);
    tick();
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 2);
    chk("single_data", rsp_data, 143);
    tick();
    chk("single_cnt", op_count, 1);
    chk("single_done", rsp_valid, 0);

    // round robin from pointer 0
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'd10);
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 5) ? 4'hF : 4'h0;
      #1;
      if (c < 5) chk("rr_grant", req_ready, 1 << (c % 4));
      if (c >= 2) begin
        chk("rr_valid", rsp_valid, 1);
        chk("rr_id", rsp_id, (c - 2) % 4);
        chk("rr_data", rsp_data, ((c - 2) % 4 + 1) * 10);
      end
      tick();
    end
    chk("rr_empty", rsp_valid, 0);
    chk("rr_cnt", op_count, 5);

    // backpressure: three ops through requester 0
    rsp_ready = 1'b0;
    set_op(0, 8'd2, 8'd3);
    req_valid = 4'b0001;
    #1;
    chk("bp_g0", req_ready, 4'b0001);
    tick();
    set_op(0, 8'd4, 8'd5);
    #1;
    chk("bp_g1", req_ready, 4'b0001);
    tick();
    set_op(0, 8'd6, 8'd7);
    for (int w = 0; w < 5; w++) begin
      #1;
      chk("bp_hold_rdy", req_ready, 0);
      chk("bp_hold_v", rsp_valid, 1);
      chk("bp_hold_d", rsp_data, 6);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_g", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("bp_d1", {rsp_valid, rsp_data}, {1'b1, 16'd20});
    tick();
    chk("bp_d2", {rsp_valid, rsp_data}, {1'b1, 16'd42});
    tick();
    chk("bp_empty", rsp_valid, 0);
    chk("bp_cnt", op_count, 8);

    // corners then exhaustive 0..31 x 0..31 on requester 0
    nx = 2 + 1024;
    for (int c = 0; c < nx + 2; c++) begin
      if (c < nx) begin
        set_op(0, op_a(c), op_b(c));
        req_valid = 4'b0001;
      end else begin
        req_valid = '0;
      end
      if (c >= 2) begin
        e16 = 16'(op_a(c - 2)) * 16'(op_b(c - 2));
        if (c == 2) e16 = 16'd65025;
        if (c == 3) e16 = 16'd0;
        chk("mul", {rsp_valid, rsp_data}, {1'b1, e16});
      end
      tick();
    end
    tick();

    // reset with S1 and S2 both valid
    rsp_ready = 1'b0;
    set_op(1, 8'd5, 8'd5);
    req_valid = 4'b0010;
    tick();
    set_op(1, 8'd6, 8'd6);
    tick();
    chk("mid_pre", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_data", rsp_data, 0);
    chk("mid_id", rsp_id, 0);
    chk("mid_cnt", op_count, 0);
    chk("mid_rdy", req_ready, 0);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("mid_stale", rsp_valid, 0);
    end
    set_op(3, 8'd3, 8'd7);
    req_valid = 4'b1000;
    #1;
    chk("mid_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    chk("mid_rsp", {rsp_valid, 14'(rsp_id), rsp_data},
        {1'b1, 14'd3, 16'd21});
    tick();

    // withdrawal of requester 1 while 0 is granted
    set_op(0, 8'd1, 8'd1);
    set_op(1, 8'd9, 8'd9);
    req_valid = 4'b0011;
    #1;
    chk("wd_grant", req_ready, 4'b0001);
    #1;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    chk("wd_rsp", {rsp_valid, 14'(rsp_id), rsp_data},
        {1'b1, 14'd0, 16'd1});
    tick();
    chk("wd_none1", rsp_valid, 0);
    tick();
    chk("wd_none2", rsp_valid, 0);
    chk("wd_cnt", op_count, 2);

    // saturation of op_count
    set_op(0, 8'd1, 8'd1);
    for (int k = 0; k < 65532; k++) begin
      req_valid = 4'b0001;
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    chk("sat_fffe", op_count, 16'hFFFE);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (3) tick();
    chk("sat_ffff", op_count, 16'hFFFF);
    req_valid = 4'b0001;
    repeat (2) tick();
    req_valid = '0;
    repeat (3) tick();
    chk("sat_hold", op_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
